// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter
//   Merges the ALU and LSU writeback streams into the single GPR write port
//   and tracks which registers still have a write outstanding.
//
//   Parameters
//     ADDR_W   GPR address width
//     DATA_W   GPR data width
//     REG_NUM  number of GPRs (2**ADDR_W)
//
//   Ports
//     clk_i, n_rst_i             clock, asynchronous active-low reset
//     alu_valid_i/alu_ready_o    ALU writeback handshake, alu_wa_i/alu_wd_i payload
//     lsu_valid_i/lsu_ready_o    LSU writeback handshake, lsu_wa_i/lsu_wd_i payload
//     issue_valid_i, issue_rd_i  instruction issuing with destination issue_rd_i
//     issue_ready_o              low when issuing would create a WAW hazard
//     rs1_ra_i/rs2_ra_i          operand addresses queried for pending writes
//     rs1_busy_o/rs2_busy_o      queried register still has a write outstanding
//     rd_we_o/rd_wa_o/rd_wd_o    registered GPR write port, one cycle after grant
module gpr_wb_arbiter #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 32
) (
  input  logic              clk_i,
  input  logic              n_rst_i,
  input  logic              alu_valid_i,
  output logic              alu_ready_o,
  input  logic [ADDR_W-1:0] alu_wa_i,
  input  logic [DATA_W-1:0] alu_wd_i,
  input  logic              lsu_valid_i,
  output logic              lsu_ready_o,
  input  logic [ADDR_W-1:0] lsu_wa_i,
  input  logic [DATA_W-1:0] lsu_wd_i,
  input  logic              issue_valid_i,
  input  logic [ADDR_W-1:0] issue_rd_i,
  output logic              issue_ready_o,
  input  logic [ADDR_W-1:0] rs1_ra_i,
  input  logic [ADDR_W-1:0] rs2_ra_i,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o,
  output logic              rd_we_o,
  output logic [ADDR_W-1:0] rd_wa_o,
  output logic [DATA_W-1:0] rd_wd_o
);

  // Which source wins the next contested cycle.
  typedef enum logic {
    PRI_LSU = 1'b0,
    PRI_ALU = 1'b1
  } pri_t;

  pri_t               pri;
  pri_t               pri_next;
  logic [REG_NUM-1:0] busy;
  logic [REG_NUM-1:0] busy_next;
  logic               alu_grant;
  logic               lsu_grant;
  logic               grant;
  logic               gnt_write;
  logic [ADDR_W-1:0]  gnt_wa;
  logic [DATA_W-1:0]  gnt_wd;
  logic               issue_fire;

  // Arbitration: a lone requester always wins; the pointer only decides
  // (and only moves) when both sources request together. Nothing is
  // granted while reset is held.
  always_comb begin
    alu_grant = 1'b0;
    lsu_grant = 1'b0;
    pri_next  = pri;
    if (n_rst_i) begin
      if (alu_valid_i && lsu_valid_i) begin
        if (pri == PRI_LSU) begin
          lsu_grant = 1'b1;
          pri_next  = PRI_ALU;
        end else begin
          alu_grant = 1'b1;
          pri_next  = PRI_LSU;
        end
      end else begin
        alu_grant = alu_valid_i;
        lsu_grant = lsu_valid_i;
      end
    end
  end

  assign grant       = alu_grant | lsu_grant;
  assign gnt_wa      = lsu_grant ? lsu_wa_i : alu_wa_i;
  assign gnt_wd      = lsu_grant ? lsu_wd_i : alu_wd_i;
  // Writes to x0 are accepted but dropped.
  assign gnt_write   = grant && (gnt_wa != '0);

  assign alu_ready_o = alu_grant;
  assign lsu_ready_o = lsu_grant;

  // A busy destination may still issue if its outstanding write retires in
  // this very cycle; the new issue then re-marks it busy.
  assign issue_ready_o = n_rst_i &&
                         !(busy[issue_rd_i] && !(grant && (gnt_wa == issue_rd_i)));
  assign issue_fire    = issue_valid_i && issue_ready_o && (issue_rd_i != '0);

  assign rs1_busy_o = (rs1_ra_i != '0) && busy[rs1_ra_i];
  assign rs2_busy_o = (rs2_ra_i != '0) && busy[rs2_ra_i];

  // Scoreboard update: clear first, then set, so a same-edge issue to the
  // retiring register leaves it busy. Bit 0 is pinned low.
  always_comb begin
    busy_next = busy;
    if (gnt_write) begin
      busy_next[gnt_wa] = 1'b0;
    end
    if (issue_fire) begin
      busy_next[issue_rd_i] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // State and the registered write port. Address/data only move on a real
  // write so they keep their last values while the port is idle.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      pri     <= PRI_LSU;
      busy    <= '0;
      rd_we_o <= 1'b0;
      rd_wa_o <= '0;
      rd_wd_o <= '0;
    end else begin
      pri     <= pri_next;
      busy    <= busy_next;
      rd_we_o <= gnt_write;
      if (gnt_write) begin
        rd_wa_o <= gnt_wa;
        rd_wd_o <= gnt_wd;
      end
    end
  end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb_gpr_wb_arbiter
//   Directed bench for gpr_wb_arbiter. Expected GPR writes are queued when
//   the stimulus is applied; a monitor retires them as the write port fires.
//   Handshake and hazard outputs are compared directly against hand values.
module tb_gpr_wb_arbiter;

  logic        clk_i;
  logic        n_rst_i;
  logic        alu_valid_i;
  logic        alu_ready_o;
  logic [4:0]  alu_wa_i;
  logic [31:0] alu_wd_i;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [4:0]  lsu_wa_i;
  logic [31:0] lsu_wd_i;
  logic        issue_valid_i;
  logic [4:0]  issue_rd_i;
  logic        issue_ready_o;
  logic [4:0]  rs1_ra_i;
  logic [4:0]  rs2_ra_i;
  logic        rs1_busy_o;
  logic        rs2_busy_o;
  logic        rd_we_o;
  logic [4:0]  rd_wa_o;
  logic [31:0] rd_wd_o;

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  gpr_wb_arbiter #(
    .ADDR_W (5),
    .DATA_W (32),
    .REG_NUM(32)
  ) dut (
    .clk_i        (clk_i),
    .n_rst_i      (n_rst_i),
    .alu_valid_i  (alu_valid_i),
    .alu_ready_o  (alu_ready_o),
    .alu_wa_i     (alu_wa_i),
    .alu_wd_i     (alu_wd_i),
    .lsu_valid_i  (lsu_valid_i),
    .lsu_ready_o  (lsu_ready_o),
    .lsu_wa_i     (lsu_wa_i),
    .lsu_wd_i     (lsu_wd_i),
    .issue_valid_i(issue_valid_i),
    .issue_rd_i   (issue_rd_i),
    .issue_ready_o(issue_ready_o),
    .rs1_ra_i     (rs1_ra_i),
    .rs2_ra_i     (rs2_ra_i),
    .rs1_busy_o   (rs1_busy_o),
    .rs2_busy_o   (rs2_busy_o),
    .rd_we_o      (rd_we_o),
    .rd_wa_o      (rd_wa_o),
    .rd_wd_o      (rd_wd_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs on the falling edge and let it settle.
  task automatic applyStimulus(input logic av, input logic [4:0] awa, input logic [31:0] awd,
                               input logic lv, input logic [4:0] lwa, input logic [31:0] lwd,
                               input logic iv, input logic [4:0] ird,
                               input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk_i);
    alu_valid_i   = av;
    alu_wa_i      = awa;
    alu_wd_i      = awd;
    lsu_valid_i   = lv;
    lsu_wa_i      = lwa;
    lsu_wd_i      = lwd;
    issue_valid_i = iv;
    issue_rd_i    = ird;
    rs1_ra_i      = r1;
    rs2_ra_i      = r2;
    #1;
  endtask

  task automatic expectWrite(input logic [4:0] wa, input logic [31:0] wd);
    wr_t w;
    w.wa = wa;
    w.wd = wd;
    exp_q.push_back(w);
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every registered write must match the oldest expected one.
  always @(posedge clk_i) begin
    #1;
    if (rd_we_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got wa=%0d wd=0x%0h, expected no write",
                 rd_wa_o, rd_wd_o);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        checkOutput("write_wa", 32'(rd_wa_o), 32'(w.wa));
        checkOutput("write_wd", rd_wd_o, w.wd);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_rst_i       = 1'b0;
    alu_valid_i   = 1'b1;
    alu_wa_i      = 5'd4;
    alu_wd_i      = 32'h1234;
    lsu_valid_i   = 1'b1;
    lsu_wa_i      = 5'd6;
    lsu_wd_i      = 32'h5678;
    issue_valid_i = 1'b1;
    issue_rd_i    = 5'd2;
    rs1_ra_i      = 5'd0;
    rs2_ra_i      = 5'd0;
    #2;

    // Reset state, with requests present to show readies are forced low.
    checkOutput("rst_rd_we", 32'(rd_we_o), 0);
    checkOutput("rst_rd_wa", 32'(rd_wa_o), 0);
    checkOutput("rst_rd_wd", rd_wd_o, 0);
    checkOutput("rst_alu_ready", 32'(alu_ready_o), 0);
    checkOutput("rst_lsu_ready", 32'(lsu_ready_o), 0);
    checkOutput("rst_issue_ready", 32'(issue_ready_o), 0);
    idle();
    n_rst_i = 1'b1;
    idle();

    // Contested for four cycles: LSU, ALU, LSU, ALU; losers hold payload.
    applyStimulus(1, 1, 32'hA1, 1, 2, 32'hB1, 0, 0, 0, 0);
    checkOutput("rr1_lsu_ready", 32'(lsu_ready_o), 1);
    checkOutput("rr1_alu_ready", 32'(alu_ready_o), 0);
    expectWrite(2, 32'hB1);
    applyStimulus(1, 1, 32'hA1, 1, 3, 32'hB2, 0, 0, 0, 0);
    checkOutput("rr2_alu_ready", 32'(alu_ready_o), 1);
    checkOutput("rr2_lsu_ready", 32'(lsu_ready_o), 0);
    expectWrite(1, 32'hA1);
    applyStimulus(1, 4, 32'hA2, 1, 3, 32'hB2, 0, 0, 0, 0);
    checkOutput("rr3_lsu_ready", 32'(lsu_ready_o), 1);
    checkOutput("rr3_alu_ready", 32'(alu_ready_o), 0);
    expectWrite(3, 32'hB2);
    applyStimulus(1, 4, 32'hA2, 1, 6, 32'hB3, 0, 0, 0, 0);
    checkOutput("rr4_alu_ready", 32'(alu_ready_o), 1);
    checkOutput("rr4_lsu_ready", 32'(lsu_ready_o), 0);
    expectWrite(4, 32'hA2);
    idle();

    // Issue rd=5, then a lone ALU write to 5 retires it.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5, 0, 0);
    checkOutput("iss5_ready", 32'(issue_ready_o), 1);
    applyStimulus(1, 5, 32'h11, 0, 0, 0, 0, 0, 5, 5);
    checkOutput("alu5_ready", 32'(alu_ready_o), 1);
    checkOutput("busy5_rs1", 32'(rs1_busy_o), 1);
    checkOutput("busy5_rs2", 32'(rs2_busy_o), 1);
    expectWrite(5, 32'h11);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
    checkOutput("busy5_cleared", 32'(rs1_busy_o), 0);

    // A lone grant must not have moved the pointer: LSU wins next contest.
    applyStimulus(1, 8, 32'hC1, 1, 9, 32'hD1, 0, 0, 0, 0);
    checkOutput("rr5_lsu_ready", 32'(lsu_ready_o), 1);
    checkOutput("rr5_alu_ready", 32'(alu_ready_o), 0);
    expectWrite(9, 32'hD1);
    applyStimulus(1, 8, 32'hC1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("alu8_ready", 32'(alu_ready_o), 1);
    expectWrite(8, 32'hC1);

    // WAW hazard on 7, released by a same-cycle LSU write to 7.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    checkOutput("iss7_first", 32'(issue_ready_o), 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    checkOutput("iss7_blocked", 32'(issue_ready_o), 0);
    applyStimulus(0, 0, 0, 1, 7, 32'h77, 1, 7, 0, 0);
    checkOutput("iss7_released", 32'(issue_ready_o), 1);
    checkOutput("lsu7_ready", 32'(lsu_ready_o), 1);
    expectWrite(7, 32'h77);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    checkOutput("busy7_reset_wins", 32'(rs1_busy_o), 1);
    applyStimulus(0, 0, 0, 1, 7, 32'h78, 0, 0, 0, 0);
    expectWrite(7, 32'h78);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    checkOutput("busy7_cleared", 32'(rs1_busy_o), 0);

    // Write to x0 is accepted but produces no write (monitor flags any).
    applyStimulus(0, 0, 0, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
    checkOutput("x0_lsu_ready", 32'(lsu_ready_o), 1);
    checkOutput("x0_rs1_busy", 32'(rs1_busy_o), 0);
    checkOutput("x0_issue_ready", 32'(issue_ready_o), 1);
    idle();

    // Reset mid-operation: busy[3] set, write to 12 registered, grant pending.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
    applyStimulus(0, 0, 0, 1, 12, 32'hC0, 0, 0, 0, 0);
    expectWrite(12, 32'hC0);
    applyStimulus(1, 9, 32'h99, 1, 10, 32'hAA, 1, 3, 3, 0);
    checkOutput("pre_rst_alu_ready", 32'(alu_ready_o), 1);
    checkOutput("pre_rst_lsu_ready", 32'(lsu_ready_o), 0);
    checkOutput("pre_rst_busy3", 32'(rs1_busy_o), 1);
    checkOutput("pre_rst_issue3", 32'(issue_ready_o), 0);
    checkOutput("pre_rst_rd_we", 32'(rd_we_o), 1);
    #1;
    n_rst_i = 1'b0;
    #1;
    checkOutput("mid_rst_rd_we", 32'(rd_we_o), 0);
    checkOutput("mid_rst_rd_wa", 32'(rd_wa_o), 0);
    checkOutput("mid_rst_rd_wd", rd_wd_o, 0);
    checkOutput("mid_rst_busy3", 32'(rs1_busy_o), 0);
    checkOutput("mid_rst_alu_ready", 32'(alu_ready_o), 0);
    checkOutput("mid_rst_lsu_ready", 32'(lsu_ready_o), 0);
    checkOutput("mid_rst_issue_ready", 32'(issue_ready_o), 0);
    alu_valid_i   = 1'b0;
    lsu_valid_i   = 1'b0;
    issue_valid_i = 1'b0;
    #1;
    n_rst_i = 1'b1;
    idle();

    // Pointer returned to LSU-first.
    applyStimulus(1, 9, 32'h99, 1, 10, 32'hAA, 0, 0, 0, 0);
    checkOutput("post_rst_lsu_ready", 32'(lsu_ready_o), 1);
    checkOutput("post_rst_alu_ready", 32'(alu_ready_o), 0);
    expectWrite(10, 32'hAA);
    applyStimulus(1, 9, 32'h99, 0, 0, 0, 0, 0, 0, 0);
    expectWrite(9, 32'h99);
    idle();
    idle();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(posedge clk_i);
    end
    #2;
    checkOutput("queue_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
